// File: rtl/pc_pkg.sv
// Shared program-counter definitions: next-PC source encoding and fetch defaults.
// Also imported by the fetch stage so both agree on reset vector and step size.
package pc_pkg;

    localparam logic [1:0] SRC_SEQ = 2'd0;
    localparam logic [1:0] SRC_BR  = 2'd1;
    localparam logic [1:0] SRC_JMP = 2'd2;
    localparam logic [1:0] SRC_RET = 2'd3;

    localparam int unsigned DEFAULT_INSTR_BYTES  = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: the newest entry sits just below the write pointer.
// A push when full silently overwrites the oldest slot; pulses report over/underflow.
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_push_data,
    output logic [WIDTH-1:0]             o_top,
    output logic [$clog2(RAS_DEPTH):0]   o_count,
    output logic                         o_overflow,
    output logic                         o_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_top_idx;

    assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_top_idx = r_ptr - PTR_W'(1);

    // Pop has priority so a simultaneous request never pushes.
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & ~i_pop;

    assign o_top       = r_mem[w_top_idx];
    assign o_count     = r_count;
    assign o_overflow  = w_do_push & w_full;
    assign o_underflow = i_pop & w_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_do_pop) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CNT_W'(1);
        end else if (w_do_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (!w_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit: priority next-PC mux (ret > call/jump > branch > sequential),
// PC register, and a return-address stack with a sticky over/underflow flag.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int               INSTR_BYTES  = DEFAULT_INSTR_BYTES,
    parameter int               RAS_DEPTH    = 4,
    parameter int               CNT_W        = $clog2(RAS_DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [WIDTH-1:0] i_branch_offset,
    input  logic             i_jump,
    input  logic             i_call,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic             i_ret,
    output logic [WIDTH-1:0] o_pc_out,
    output logic [WIDTH-1:0] o_pc_next,
    output logic [CNT_W-1:0] o_ras_count,
    output logic             o_ras_full,
    output logic             o_ras_empty,
    output logic             o_ras_err
);

    logic [WIDTH-1:0] r_pc;
    logic             r_err;

    logic [WIDTH-1:0] w_pc_seq;
    logic [WIDTH-1:0] w_pc_br;
    logic [WIDTH-1:0] w_ras_top;
    logic [1:0]       w_src;
    logic             w_push;
    logic             w_pop;
    logic             w_overflow;
    logic             w_underflow;

    assign w_pc_seq = r_pc + WIDTH'(INSTR_BYTES);
    assign w_pc_br  = r_pc + i_branch_offset;

    // Only the ret path touches the stack; a call alongside ret must not push.
    assign w_push = i_call & ~i_ret & ~i_stall;
    assign w_pop  = i_ret & ~i_stall;

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_seq),
        .o_top       (w_ras_top),
        .o_count     (o_ras_count),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow)
    );

    assign o_ras_full  = (o_ras_count == CNT_W'(RAS_DEPTH));
    assign o_ras_empty = (o_ras_count == '0);

    // A ret on an empty stack still beats everything else but falls through as sequential.
    always_comb begin
        w_src = SRC_SEQ;
        if (i_ret) begin
            w_src = o_ras_empty ? SRC_SEQ : SRC_RET;
        end else if (i_call || i_jump) begin
            w_src = SRC_JMP;
        end else if (i_branch_taken) begin
            w_src = SRC_BR;
        end
    end

    always_comb begin
        o_pc_next = w_pc_seq;
        case (w_src)
            SRC_BR:  o_pc_next = w_pc_br;
            SRC_JMP: o_pc_next = i_jump_target;
            SRC_RET: o_pc_next = w_ras_top;
            default: o_pc_next = w_pc_seq;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc  <= RESET_VECTOR;
            r_err <= 1'b0;
        end else if (!i_stall) begin
            r_pc  <= o_pc_next;
            r_err <= r_err | w_overflow | w_underflow;
        end
    end

    assign o_pc_out  = r_pc;
    assign o_ras_err = r_err;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras: each task drives a scenario and checks hand-computed values.
module tb_pc_unit_ras;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic [31:0] jump_target = '0;
    logic        ret = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] pc_next;
    logic [2:0]  ras_count;
    logic        ras_full;
    logic        ras_empty;
    logic        ras_err;

    int n_vec = 0;
    int n_err = 0;

    pc_unit_ras dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_offset (branch_offset),
        .i_jump          (jump),
        .i_call          (call),
        .i_jump_target   (jump_target),
        .i_ret           (ret),
        .o_pc_out        (pc_out),
        .o_pc_next       (pc_next),
        .o_ras_count     (ras_count),
        .o_ras_full      (ras_full),
        .o_ras_empty     (ras_empty),
        .o_ras_err       (ras_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; branch_taken = 0; branch_offset = '0;
        jump = 0; call = 0; jump_target = '0; ret = 0;
    endtask

    task automatic go_to(input logic [31:0] target);
        idle(); jump = 1; jump_target = target; step(); idle();
        n_vec++; if (pc_out !== target) begin n_err++; $display("FAIL goto_pc got %h exp %h", pc_out, target); end
    endtask

    task automatic test_reset();
        idle(); reset = 1; step(); step(); idle();
        n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
        n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", ras_count); end
        n_vec++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin n_err++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", ras_empty, ras_full); end
        n_vec++; if (ras_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", ras_err); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_pc = 32'(i * 4);
            n_vec++; if (pc_out !== exp_pc) begin n_err++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc_out, exp_pc); end
        end
        n_vec++; if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin n_err++; $display("FAIL seq_flags got empty=%b err=%b exp 1 0", ras_empty, ras_err); end
    endtask

    task automatic test_branch_stall();
        branch_taken = 1; branch_offset = 32'hFFFF_FFF8;
        #1;
        n_vec++; if (pc_next !== 32'h08) begin n_err++; $display("FAIL branch_next got %h exp %h", pc_next, 32'h08); end
        step();
        n_vec++; if (pc_out !== 32'h08) begin n_err++; $display("FAIL branch_pc got %h exp %h", pc_out, 32'h08); end
        stall = 1;
        #1;
        n_vec++; if (pc_next !== 32'h00) begin n_err++; $display("FAIL stall_next got %h exp %h", pc_next, 32'h00); end
        step();
        n_vec++; if (pc_out !== 32'h08) begin n_err++; $display("FAIL stall_pc got %h exp %h", pc_out, 32'h08); end
        idle();
    endtask

    task automatic test_call_ret();
        go_to(32'h20);
        call = 1; jump_target = 32'h100; step(); idle();
        n_vec++; if (pc_out !== 32'h100) begin n_err++; $display("FAIL call_pc got %h exp %h", pc_out, 32'h100); end
        n_vec++; if (ras_count !== 3'd1) begin n_err++; $display("FAIL call_count got %0d exp 1", ras_count); end
        // Stalled call must leave PC and stack alone.
        stall = 1; call = 1; jump_target = 32'h500; step(); idle();
        n_vec++; if (pc_out !== 32'h100 || ras_count !== 3'd1) begin n_err++; $display("FAIL stall_call got pc=%h cnt=%0d exp 100 1", pc_out, ras_count); end
        ret = 1; #1;
        n_vec++; if (pc_next !== 32'h24) begin n_err++; $display("FAIL ret_next got %h exp %h", pc_next, 32'h24); end
        step(); idle();
        n_vec++; if (pc_out !== 32'h24) begin n_err++; $display("FAIL ret_pc got %h exp %h", pc_out, 32'h24); end
        n_vec++; if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin n_err++; $display("FAIL ret_flags got empty=%b err=%b exp 1 0", ras_empty, ras_err); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h404; exp_ret[1] = 32'h304; exp_ret[2] = 32'h204; exp_ret[3] = 32'h104;
        go_to(32'h0);
        for (int i = 1; i <= 5; i++) begin
            call = 1; jump_target = 32'(i * 32'h100); step(); idle();
        end
        n_vec++; if (pc_out !== 32'h500) begin n_err++; $display("FAIL ovf_pc got %h exp %h", pc_out, 32'h500); end
        n_vec++; if (ras_count !== 3'd4 || ras_full !== 1'b1) begin n_err++; $display("FAIL ovf_count got %0d full=%b exp 4 1", ras_count, ras_full); end
        n_vec++; if (ras_err !== 1'b1) begin n_err++; $display("FAIL ovf_err got %b exp 1", ras_err); end
        for (int i = 0; i < 4; i++) begin
            ret = 1; step(); idle();
            n_vec++; if (pc_out !== exp_ret[i]) begin n_err++; $display("FAIL ovf_ret[%0d] got %h exp %h", i, pc_out, exp_ret[i]); end
        end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ovf_drain got empty=%b exp 1", ras_empty); end
    endtask

    task automatic test_underflow();
        idle(); reset = 1; step(); idle();
        go_to(32'h40);
        n_vec++; if (ras_err !== 1'b0) begin n_err++; $display("FAIL unf_pre_err got %b exp 0", ras_err); end
        ret = 1; step(); idle();
        n_vec++; if (pc_out !== 32'h44 || ras_err !== 1'b1) begin n_err++; $display("FAIL unf_ret got pc=%h err=%b exp 44 1", pc_out, ras_err); end
        n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL unf_count got %0d exp 0", ras_count); end
        ret = 1; jump = 1; jump_target = 32'h80; step(); idle();
        n_vec++; if (pc_out !== 32'h48) begin n_err++; $display("FAIL unf_ret_jump got %h exp %h", pc_out, 32'h48); end
        // ret wins over call and the call does not push.
        call = 1; jump_target = 32'h100; step(); idle();
        ret = 1; call = 1; jump_target = 32'h300; step(); idle();
        n_vec++; if (pc_out !== 32'h4C || ras_count !== 3'd0) begin n_err++; $display("FAIL ret_call got pc=%h cnt=%0d exp 4c 0", pc_out, ras_count); end
    endtask

    task automatic test_wrap_and_reset();
        go_to(32'hFFFF_FFFC);
        step();
        n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h exp %h", pc_out, 32'h0); end
        call = 1; jump_target = 32'h200; step(); idle();
        n_vec++; if (ras_count !== 3'd1 || ras_err !== 1'b1) begin n_err++; $display("FAIL pre_reset got cnt=%0d err=%b exp 1 1", ras_count, ras_err); end
        reset = 1; call = 1; jump_target = 32'h300; step(); idle();
        n_vec++; if (pc_out !== 32'h0 || ras_count !== 3'd0 || ras_err !== 1'b0) begin n_err++; $display("FAIL reset_call got pc=%h cnt=%0d err=%b exp 0 0 0", pc_out, ras_count, ras_err); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        test_reset();
        test_sequential();
        test_branch_stall();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
